// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// arbitration mode selectors and a channel-index wrap helper.
package mem_bus_pkg;

  typedef logic [1:0] arbState_t;

  localparam arbState_t IDLE   = 2'd0;
  localparam arbState_t ACCESS = 2'd1;
  localparam arbState_t DONE   = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Next channel index after idx, wrapping from n-1 back to 0.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner pick: first eligible channel found searching
// upward from the base pointer (base pinned to 0 in fixed-priority mode).
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int RR_MODE = ARB_FIXED
) (
  input  logic [NUM_CH-1:0]         eligible,
  input  logic [$clog2(NUM_CH)-1:0] basePtr,
  output logic                      anyValid,
  output logic [NUM_CH-1:0]         pickOneHot,
  output logic [$clog2(NUM_CH)-1:0] pickIdx
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] startIdx;

  assign startIdx = (RR_MODE == ARB_RR) ? basePtr : '0;
  assign anyValid = |eligible;

  // Walk offsets from farthest to nearest so the nearest eligible channel is
  // the last one written and therefore wins.
  always_comb begin
    int cand;
    cand       = 0;
    pickOneHot = '0;
    pickIdx    = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = int'(startIdx) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (eligible[cand]) begin
        pickOneHot       = '0;
        pickOneHot[cand] = 1'b1;
        pickIdx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates NUM_CH requesters onto one SRAM / memory-mapped bus with a
// req/ack handshake, wait states and RAM vs mapped-space address decode.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] MAP_BASE    = 'hF000,
  parameter int                WAIT_CYCLES = 1,
  parameter int                RR_MODE     = ARB_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH-1:0]        wr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  output logic                     bus_oe,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic                     bus_wr,
  output logic                     bus_ram_en,
  output logic                     bus_map_en
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  logic [ADDR_W-1:0] chAddr  [NUM_CH];
  logic [DATA_W-1:0] chWdata [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign chAddr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign chWdata[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arbState_t         stateReg;
  logic [CNT_W-1:0]  waitCntReg;
  logic [IDX_W-1:0]  rrPtrReg;
  logic [IDX_W-1:0]  winIdxReg;
  logic              writeReg;
  logic [NUM_CH-1:0] gntReg;
  logic [NUM_CH-1:0] ackReg;
  logic [DATA_W-1:0] rdataReg;
  logic [ADDR_W-1:0] busAddrReg;
  logic [DATA_W-1:0] busWdataReg;
  logic              busWrReg;
  logic              busRamEnReg;
  logic              busMapEnReg;

  logic [NUM_CH-1:0] eligible;
  logic              anyValid;
  logic [NUM_CH-1:0] pickOneHot;
  logic [IDX_W-1:0]  pickIdx;
  logic              mapHit;

  assign eligible = req & ch_mask;
  assign mapHit   = (chAddr[pickIdx] >= MAP_BASE);

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .eligible   (eligible),
    .basePtr    (rrPtrReg),
    .anyValid   (anyValid),
    .pickOneHot (pickOneHot),
    .pickIdx    (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      waitCntReg  <= '0;
      rrPtrReg    <= '0;
      winIdxReg   <= '0;
      writeReg    <= 1'b0;
      gntReg      <= '0;
      ackReg      <= '0;
      rdataReg    <= '0;
      busAddrReg  <= '0;
      busWdataReg <= '0;
      busWrReg    <= 1'b0;
      busRamEnReg <= 1'b0;
      busMapEnReg <= 1'b0;
    end else begin
      ackReg <= '0;
      case (stateReg)
        IDLE: begin
          if (anyValid) begin
            stateReg    <= ACCESS;
            winIdxReg   <= pickIdx;
            gntReg      <= pickOneHot;
            busAddrReg  <= chAddr[pickIdx];
            busWdataReg <= chWdata[pickIdx];
            writeReg    <= wr[pickIdx];
            busWrReg    <= wr[pickIdx];
            busMapEnReg <= mapHit;
            busRamEnReg <= ~mapHit;
            waitCntReg  <= CNT_W'(1);
          end
        end
        ACCESS: begin
          // Counter only advances below the terminal count, so it never wraps.
          if (waitCntReg >= CNT_LAST) begin
            stateReg    <= DONE;
            waitCntReg  <= '0;
            busWrReg    <= 1'b0;
            busRamEnReg <= 1'b0;
            busMapEnReg <= 1'b0;
            ackReg      <= gntReg;
            if (!writeReg) rdataReg <= bus_rdata;
          end else begin
            waitCntReg <= waitCntReg + 1'b1;
          end
        end
        DONE: begin
          stateReg <= IDLE;
          gntReg   <= '0;
          rrPtrReg <= IDX_W'(wrapInc(int'(winIdxReg), NUM_CH));
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign gnt        = gntReg;
  assign ack        = ackReg;
  assign rdata      = rdataReg;
  assign bus_addr   = busAddrReg;
  assign bus_wdata  = busWdataReg;
  assign bus_oe     = busWrReg;
  assign bus_wr     = busWrReg;
  assign bus_ram_en = busRamEnReg;
  assign bus_map_en = busMapEnReg;

endmodule
